// File: rtl/unit_test_sequencer.sv
// Initiator end of the unit-test start/finish handshake: on go, launches every enabled
// test in index order, waits for finish or timeout, and records timeouts, stale finishes and cycle counts.
module unit_test_sequencer #(
  parameter int N_TESTS = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               go,
  input  logic [N_TESTS-1:0]                 en_mask,
  input  logic [N_TESTS-1:0]                 finish,
  output logic [N_TESTS-1:0]                 start,
  output logic                               busy,
  output logic                               done,
  output logic [4:0]                         cur_idx,
  output logic [N_TESTS-1:0]                 timeout_mask,
  output logic [N_TESTS-1:0]                 stale_mask,
  output logic [$clog2(TIMEOUT+1)-1:0]       last_cycles,
  output logic [31:0]                        total_cycles
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int IW = (N_TESTS > 1) ? $clog2(N_TESTS) : 1;

  // Handshake: start[i] is the request, held high until finish[i] is sampled high
  // or TIMEOUT wait cycles elapse; start drops on the edge that leaves WAIT.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_NEXT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [N_TESTS-1:0]  start_nxt;
  logic [4:0]          idx_nxt;
  logic [CW-1:0]       timer, timer_nxt;
  logic [N_TESTS-1:0]  tmask_nxt, smask_nxt;
  logic [CW-1:0]       last_nxt;
  logic [31:0]         total_nxt;

  logic [IW-1:0]       idx;
  logic [CW-1:0]       t;
  logic [32:0]         sum_wide;
  logic [31:0]         total_sat;

  assign idx       = cur_idx[IW-1:0];
  assign t         = timer + CW'(1);
  assign sum_wide  = 33'(total_cycles) + 33'(t);
  assign total_sat = sum_wide[32] ? 32'hFFFF_FFFF : sum_wide[31:0];

  assign busy = (state == S_LAUNCH) || (state == S_WAIT) || (state == S_NEXT);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      start        <= '0;
      cur_idx      <= '0;
      timer        <= '0;
      timeout_mask <= '0;
      stale_mask   <= '0;
      last_cycles  <= '0;
      total_cycles <= '0;
    end else begin
      state        <= state_nxt;
      start        <= start_nxt;
      cur_idx      <= idx_nxt;
      timer        <= timer_nxt;
      timeout_mask <= tmask_nxt;
      stale_mask   <= smask_nxt;
      last_cycles  <= last_nxt;
      total_cycles <= total_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_nxt = start;
    idx_nxt   = cur_idx;
    timer_nxt = timer;
    tmask_nxt = timeout_mask;
    smask_nxt = stale_mask;
    last_nxt  = last_cycles;
    total_nxt = total_cycles;

    case (state)
      S_IDLE, S_DONE: begin
        if (go) begin
          idx_nxt   = '0;
          tmask_nxt = '0;
          smask_nxt = '0;
          last_nxt  = '0;
          total_nxt = '0;
          state_nxt = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        if (!en_mask[idx]) begin
          state_nxt = S_NEXT;
        end else begin
          if (finish[idx]) smask_nxt[idx] = 1'b1;
          start_nxt      = '0;
          start_nxt[idx] = 1'b1;
          timer_nxt      = '0;
          state_nxt      = S_WAIT;
        end
      end

      S_WAIT: begin
        // finish is checked first so it wins over a coincident timeout
        if (finish[idx]) begin
          last_nxt  = t;
          total_nxt = total_sat;
          start_nxt = '0;
          state_nxt = S_NEXT;
        end else if (t == CW'(TIMEOUT)) begin
          tmask_nxt[idx] = 1'b1;
          last_nxt       = t;
          total_nxt      = total_sat;
          start_nxt      = '0;
          state_nxt      = S_NEXT;
        end else begin
          timer_nxt = t;
        end
      end

      S_NEXT: begin
        start_nxt = '0;
        if (cur_idx == 5'(N_TESTS - 1)) begin
          state_nxt = S_DONE;
        end else begin
          idx_nxt   = cur_idx + 5'd1;
          state_nxt = S_LAUNCH;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
